// File: rtl/compensation_weight_loader.sv
// Streams ROWS 4-bit compensation weights from Compensation_Memory into one CPE
// column, bottom row first, then flags the column as loaded.
module compensation_weight_loader #(
    parameter int ROWS       = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [3:0]            mem_rd_data,
    output logic [3:0]            Compensation_Weight,
    output logic                  Compensation_Weight_out_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  loaded
);

    localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [CNT_W-1:0]        cnt_reg;
    logic [CNT_W-1:0]        cnt_next;
    logic [CNT_W-1:0]        cnt_dec;
    logic [ADDR_WIDTH-1:0]   base_reg;
    logic [ADDR_WIDTH-1:0]   base_next;
    logic [ADDR_WIDTH-1:0]   mem_addr_next;
    logic                    mem_rd_en_next;
    logic                    rd_pending_reg;
    logic [3:0]              weight_next;
    logic                    valid_next;
    logic                    busy_next;
    logic                    done_next;
    logic                    loaded_next;

    assign cnt_dec = cnt_reg - 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg                     <= IDLE;
            cnt_reg                       <= '0;
            base_reg                      <= '0;
            rd_pending_reg                <= 1'b0;
            mem_rd_en                     <= 1'b0;
            mem_addr                      <= '0;
            Compensation_Weight           <= 4'd0;
            Compensation_Weight_out_valid <= 1'b0;
            busy                          <= 1'b0;
            done                          <= 1'b0;
            loaded                        <= 1'b0;
        end else begin
            state_reg                     <= state_next;
            cnt_reg                       <= cnt_next;
            base_reg                      <= base_next;
            rd_pending_reg                <= mem_rd_en;
            mem_rd_en                     <= mem_rd_en_next;
            mem_addr                      <= mem_addr_next;
            Compensation_Weight           <= weight_next;
            Compensation_Weight_out_valid <= valid_next;
            busy                          <= busy_next;
            done                          <= done_next;
            loaded                        <= loaded_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        base_next      = base_reg;
        mem_rd_en_next = 1'b0;
        mem_addr_next  = mem_addr;
        done_next      = 1'b0;
        loaded_next    = loaded;

        // Memory data arrives one cycle after each strobe; register it straight out.
        valid_next  = rd_pending_reg;
        weight_next = rd_pending_reg ? mem_rd_data : Compensation_Weight;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next     = READ;
                    base_next      = base_addr;
                    cnt_next       = CNT_W'(ROWS - 1);
                    mem_rd_en_next = 1'b1;
                    mem_addr_next  = base_addr + ADDR_WIDTH'(ROWS - 1);
                    loaded_next    = 1'b0;
                end
            end
            READ: begin
                if (cnt_reg != '0) begin
                    cnt_next       = cnt_dec;
                    mem_rd_en_next = 1'b1;
                    mem_addr_next  = base_reg + ADDR_WIDTH'(cnt_dec);
                end else begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Stay until the final weight has been presented on the column.
                if (!rd_pending_reg) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end
            end
            DONE: begin
                state_next  = IDLE;
                loaded_next = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_compensation_weight_loader.sv
// Directed bench for compensation_weight_loader with ROWS=4, ADDR_WIDTH=6,
// a one-cycle-latency memory model and a four-deep CPE weight chain model.
module tb_compensation_weight_loader;

    localparam int ROWS = 4;
    localparam int AW   = 6;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_rd_data;
    logic [3:0]    Compensation_Weight;
    logic          Compensation_Weight_out_valid;
    logic          busy;
    logic          done;
    logic          loaded;

    int checks = 0;
    int errors = 0;

    logic [3:0] mem [64];
    logic [3:0] chain [ROWS];

    logic          stim_start [32];
    logic [AW-1:0] stim_base  [32];
    logic          lg_rd_en   [32];
    logic [AW-1:0] lg_addr    [32];
    logic [3:0]    lg_w       [32];
    logic          lg_v       [32];
    logic          lg_busy    [32];
    logic          lg_done    [32];
    logic          lg_loaded  [32];

    compensation_weight_loader #(.ROWS(ROWS), .ADDR_WIDTH(AW)) dut (
        .clk                           (clk),
        .rst                           (rst),
        .start                         (start),
        .base_addr                     (base_addr),
        .mem_rd_en                     (mem_rd_en),
        .mem_addr                      (mem_addr),
        .mem_rd_data                   (mem_rd_data),
        .Compensation_Weight           (Compensation_Weight),
        .Compensation_Weight_out_valid (Compensation_Weight_out_valid),
        .busy                          (busy),
        .done                          (done),
        .loaded                        (loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial mem_rd_data = 4'd0;
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    // CPE weight pass chain: index 0 is the top CPE.
    always @(posedge clk) begin
        if (Compensation_Weight_out_valid) begin
            chain[0] <= Compensation_Weight;
            for (int i = 1; i < ROWS; i++) chain[i] <= chain[i-1];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic clear_stim();
        for (int i = 0; i < 32; i++) begin
            stim_start[i] = 1'b0;
            stim_base[i]  = 6'h10;
        end
    endtask

    // Cycle c inputs are applied just after a rising edge and sampled at the falling edge.
    task automatic capture(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            start     = stim_start[c];
            base_addr = stim_base[c];
            @(negedge clk);
            lg_rd_en[c]  = mem_rd_en;
            lg_addr[c]   = mem_addr;
            lg_w[c]      = Compensation_Weight;
            lg_v[c]      = Compensation_Weight_out_valid;
            lg_busy[c]   = busy;
            lg_done[c]   = done;
            lg_loaded[c] = loaded;
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset mem_rd_en got %b exp 0", mem_rd_en); end
        checks++; if (mem_addr !== 6'd0) begin errors++; $display("FAIL reset mem_addr got %h exp 00", mem_addr); end
        checks++; if (Compensation_Weight !== 4'd0) begin errors++; $display("FAIL reset weight got %h exp 0", Compensation_Weight); end
        checks++; if (Compensation_Weight_out_valid !== 1'b0) begin errors++; $display("FAIL reset valid got %b exp 0", Compensation_Weight_out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done got %b exp 0", done); end
        checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL reset loaded got %b exp 0", loaded); end
        rst = 1'b0;
        $display("test_reset complete");
    endtask

    task automatic test_basic(input string tag);
        logic [3:0]    exp_w [4];
        logic [AW-1:0] exp_a [4];
        logic [3:0]    exp_c [4];
        exp_w = '{4'hF, 4'h5, 4'hA, 4'h3};
        exp_a = '{6'h13, 6'h12, 6'h11, 6'h10};
        exp_c = '{4'h3, 4'hA, 4'h5, 4'hF};
        clear_stim();
        stim_start[0] = 1'b1;
        capture(10);
        for (int c = 0; c < 10; c++) begin
            checks++; if (lg_rd_en[c] !== (c >= 1 && c <= 4)) begin errors++; $display("FAIL %s rd_en c%0d got %b", tag, c, lg_rd_en[c]); end
            if (c >= 1 && c <= 4) begin
                checks++; if (lg_addr[c] !== exp_a[c-1]) begin errors++; $display("FAIL %s addr c%0d got %h exp %h", tag, c, lg_addr[c], exp_a[c-1]); end
            end
            checks++; if (lg_v[c] !== (c >= 3 && c <= 6)) begin errors++; $display("FAIL %s valid c%0d got %b", tag, c, lg_v[c]); end
            if (c >= 3 && c <= 6) begin
                checks++; if (lg_w[c] !== exp_w[c-3]) begin errors++; $display("FAIL %s weight c%0d got %h exp %h", tag, c, lg_w[c], exp_w[c-3]); end
            end
            checks++; if (lg_done[c] !== (c == 7)) begin errors++; $display("FAIL %s done c%0d got %b", tag, c, lg_done[c]); end
            checks++; if (lg_busy[c] !== (c >= 1 && c <= 7)) begin errors++; $display("FAIL %s busy c%0d got %b", tag, c, lg_busy[c]); end
            if (c >= 1) begin
                checks++; if (lg_loaded[c] !== (c >= 8)) begin errors++; $display("FAIL %s loaded c%0d got %b", tag, c, lg_loaded[c]); end
            end
        end
        for (int i = 0; i < ROWS; i++) begin
            checks++; if (chain[i] !== exp_c[i]) begin errors++; $display("FAIL %s chain[%0d] got %h exp %h", tag, i, chain[i], exp_c[i]); end
        end
        $display("%s load base 10 complete", tag);
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_a [4];
        logic [3:0]    exp_w [4];
        exp_a = '{6'd1, 6'd0, 6'd63, 6'd62};
        exp_w = '{4'h4, 4'h3, 4'h2, 4'h1};
        mem[62] = 4'h1; mem[63] = 4'h2; mem[0] = 4'h3; mem[1] = 4'h4;
        clear_stim();
        stim_start[0] = 1'b1; stim_base[0] = 6'd62;
        capture(10);
        checks++; if (lg_loaded[0] !== 1'b1) begin errors++; $display("FAIL wrap loaded_before got %b exp 1", lg_loaded[0]); end
        checks++; if (lg_loaded[1] !== 1'b0) begin errors++; $display("FAIL wrap loaded_cleared got %b exp 0", lg_loaded[1]); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (lg_addr[k+1] !== exp_a[k] || lg_rd_en[k+1] !== 1'b1) begin errors++; $display("FAIL wrap addr c%0d got %h/%b exp %h/1", k+1, lg_addr[k+1], lg_rd_en[k+1], exp_a[k]); end
            checks++; if (lg_w[k+3] !== exp_w[k] || lg_v[k+3] !== 1'b1) begin errors++; $display("FAIL wrap weight c%0d got %h/%b exp %h/1", k+3, lg_w[k+3], lg_v[k+3], exp_w[k]); end
        end
        checks++; if (lg_done[7] !== 1'b1) begin errors++; $display("FAIL wrap done got %b exp 1", lg_done[7]); end
        $display("test_wrap load base 62 complete");
    endtask

    task automatic test_ignored_start();
        int reads;
        logic exp_rd, exp_busy, exp_ld;
        reads = 0;
        clear_stim();
        stim_start[0] = 1'b1; stim_start[2] = 1'b1; stim_start[7] = 1'b1; stim_start[8] = 1'b1;
        stim_base[2] = 6'h30; stim_base[7] = 6'h30;
        capture(14);
        for (int c = 0; c < 14; c++) begin
            exp_rd   = (c >= 1 && c <= 4) || (c >= 9 && c <= 12);
            exp_busy = (c >= 1 && c <= 7) || (c >= 9);
            exp_ld   = (c == 8) || (c == 0);
            if (lg_rd_en[c]) reads++;
            checks++; if (lg_rd_en[c] !== exp_rd) begin errors++; $display("FAIL ignored rd_en c%0d got %b exp %b", c, lg_rd_en[c], exp_rd); end
            checks++; if (lg_busy[c] !== exp_busy) begin errors++; $display("FAIL ignored busy c%0d got %b exp %b", c, lg_busy[c], exp_busy); end
            checks++; if (lg_loaded[c] !== exp_ld) begin errors++; $display("FAIL ignored loaded c%0d got %b exp %b", c, lg_loaded[c], exp_ld); end
            checks++; if (lg_done[c] !== (c == 7)) begin errors++; $display("FAIL ignored done c%0d got %b", c, lg_done[c]); end
        end
        checks++; if (lg_addr[4] !== 6'h10 || lg_addr[9] !== 6'h13) begin errors++; $display("FAIL ignored addr got %h,%h exp 10,13", lg_addr[4], lg_addr[9]); end
        checks++; if (reads !== 8) begin errors++; $display("FAIL ignored read_count got %0d exp 8", reads); end
        repeat (8) @(posedge clk);
        $display("test_ignored_start complete");
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_w [8];
        int gap;
        logic in_win;
        exp_w = '{4'hF, 4'h5, 4'hA, 4'h3, 4'h9, 4'h8, 4'h7, 4'h6};
        mem[6'h20] = 4'h6; mem[6'h21] = 4'h7; mem[6'h22] = 4'h8; mem[6'h23] = 4'h9;
        clear_stim();
        stim_start[0] = 1'b1;
        stim_start[8] = 1'b1; stim_base[8] = 6'h20;
        capture(18);
        gap = 0;
        for (int c = 0; c < 18; c++) begin
            in_win = (c >= 3 && c <= 6) || (c >= 11 && c <= 14);
            if (c >= 7 && c <= 10 && !lg_v[c]) gap++;
            checks++; if (lg_v[c] !== in_win) begin errors++; $display("FAIL b2b valid c%0d got %b exp %b", c, lg_v[c], in_win); end
            if (in_win) begin
                checks++; if (lg_w[c] !== exp_w[(c < 8) ? c-3 : c-7]) begin errors++; $display("FAIL b2b weight c%0d got %h exp %h", c, lg_w[c], exp_w[(c < 8) ? c-3 : c-7]); end
            end
            checks++; if (lg_done[c] !== (c == 7 || c == 15)) begin errors++; $display("FAIL b2b done c%0d got %b", c, lg_done[c]); end
        end
        checks++; if (gap !== 4) begin errors++; $display("FAIL b2b gap got %0d exp 4", gap); end
        checks++; if (lg_addr[9] !== 6'h23 || lg_addr[12] !== 6'h20) begin errors++; $display("FAIL b2b addr got %h,%h exp 23,20", lg_addr[9], lg_addr[12]); end
        checks++; if (lg_loaded[16] !== 1'b1 || lg_loaded[12] !== 1'b0) begin errors++; $display("FAIL b2b loaded got %b,%b exp 1,0", lg_loaded[16], lg_loaded[12]); end
        $display("test_back_to_back loads 10 and 20 complete");
    endtask

    task automatic test_reset_mid();
        clear_stim();
        stim_start[0] = 1'b1;
        capture(4);
        checks++; if (Compensation_Weight_out_valid !== 1'b1) begin errors++; $display("FAIL rstmid valid_before got %b exp 1", Compensation_Weight_out_valid); end
        rst = 1'b1;
        #1;
        checks++; if (Compensation_Weight_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid valid got %b exp 0", Compensation_Weight_out_valid); end
        checks++; if (mem_rd_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid ctrl got rd%b busy%b done%b exp 000", mem_rd_en, busy, done); end
        checks++; if (Compensation_Weight !== 4'd0 || mem_addr !== 6'd0) begin errors++; $display("FAIL rstmid data got w%h a%h exp 0/00", Compensation_Weight, mem_addr); end
        checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL rstmid loaded got %b exp 0", loaded); end
        #3 rst = 1'b0;
        clear_stim();
        capture(8);
        for (int c = 0; c < 8; c++) begin
            checks++; if (lg_done[c] !== 1'b0 || lg_loaded[c] !== 1'b0 || lg_rd_en[c] !== 1'b0) begin errors++; $display("FAIL rstmid idle c%0d got done%b ld%b rd%b exp 000", c, lg_done[c], lg_loaded[c], lg_rd_en[c]); end
        end
        $display("test_reset_mid aborted load recovered");
        test_basic("after_reset");
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 4'h0;
        mem[6'h10] = 4'h3; mem[6'h11] = 4'hA; mem[6'h12] = 4'h5; mem[6'h13] = 4'hF;
        for (int i = 0; i < ROWS; i++) chain[i] = 4'h0;
        test_reset();
        test_basic("basic");
        test_wrap();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
